// File: rtl/pla_personality_loader.sv
// rtl/pla_personality_loader.sv - bit-serial PLA AND-plane personality loader with atomic commit
module pla_personality_loader #(
    parameter int IN_WIDTH  = 7,
    parameter int OUT_WIDTH = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    output logic                          busy,
    output logic                          done,
    output logic                          plane_valid,
    output logic [IN_WIDTH*OUT_WIDTH-1:0] plane,
    output logic [$clog2(OUT_WIDTH+1)-1:0] row_cnt
);

    localparam int PW    = IN_WIDTH * OUT_WIDTH;
    localparam int BC_W  = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int RC_W  = $clog2(OUT_WIDTH + 1);
    localparam int IDX_W = (PW > 1) ? $clog2(PW) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t            state;
    logic [BC_W-1:0]   bit_cnt;
    logic [PW-1:0]     shadow;
    logic [PW-1:0]     shadow_next;
    logic [IDX_W-1:0]  bit_idx;
    logic              row_last_bit;
    logic              plane_last_bit;

    // Position of the incoming bit: first column of a row lands in the row MSB.
    always_comb begin
        bit_idx        = IDX_W'(row_cnt) * IDX_W'(IN_WIDTH) + IDX_W'(IN_WIDTH - 1) - IDX_W'(bit_cnt);
        shadow_next    = shadow;
        shadow_next[bit_idx] = bit_in;
        row_last_bit   = (bit_cnt == BC_W'(IN_WIDTH - 1));
        plane_last_bit = row_last_bit && (row_cnt == RC_W'(OUT_WIDTH - 1));
    end

    // Load FSM: assembles rows in the shadow buffer and commits the whole plane at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            row_cnt     <= '0;
            shadow      <= '0;
            plane       <= '0;
            plane_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Any bit_valid alongside start is intentionally dropped.
                    if (start) begin
                        state   <= LOAD;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        row_cnt <= '0;
                        shadow  <= '0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        bit_cnt <= '0;
                        row_cnt <= '0;
                    end else if (bit_valid) begin
                        shadow <= shadow_next;
                        if (row_last_bit) begin
                            bit_cnt <= '0;
                            row_cnt <= row_cnt + RC_W'(1);
                        end else begin
                            bit_cnt <= bit_cnt + BC_W'(1);
                        end
                        if (plane_last_bit) begin
                            plane       <= shadow_next;
                            plane_valid <= 1'b1;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pla_personality_loader.sv
// tb/tb_pla_personality_loader.sv - scoreboard bench for pla_personality_loader
module tb_pla_personality_loader;

    localparam int IW = 7;
    localparam int OW = 3;
    localparam int PW = IW * OW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          bit_in;
    logic          bit_valid;
    logic          busy;
    logic          done;
    logic          plane_valid;
    logic [PW-1:0] plane;
    logic [1:0]    row_cnt;

    int vectors = 0;
    int miscompares = 0;
    logic [PW-1:0] exp_q[$];

    pla_personality_loader #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .bit_in(bit_in), .bit_valid(bit_valid), .busy(busy), .done(done),
        .plane_valid(plane_valid), .plane(plane), .row_cnt(row_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every done pulse must match the oldest expected plane.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done=1 with plane %b, expected no done", plane);
                end else begin
                    logic [PW-1:0] e;
                    e = exp_q.pop_front();
                    check("sb_plane", plane, e);
                    check("sb_plane_valid", PW'(plane_valid), PW'(1));
                end
            end
        end
    end

    // Serialise bits [first, first+count) of a plane: row 0 first, column a1 (row MSB) first.
    task automatic send_bits(input logic [PW-1:0] pl, input int first, input int count, input bit gaps);
        for (int k = first; k < first + count; k++) begin
            if (gaps) begin
                int ng;
                ng = $urandom_range(0, 3);
                for (int g = 0; g < ng; g++) begin
                    bit_valid = 1'b0;
                    bit_in    = 1'($urandom);
                    tick();
                end
            end
            bit_in    = pl[(k / IW) * IW + (IW - 1) - (k % IW)];
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Full load ending with a check that done appears exactly the cycle after the last bit.
    task automatic full_load(input string name, input logic [PW-1:0] pl, input bit gaps);
        pulse_start();
        check({name, "_busy_start"}, PW'(busy), PW'(1));
        exp_q.push_back(pl);
        send_bits(pl, 0, PW, gaps);
        check({name, "_done_pulse"}, PW'(done), PW'(1));
        check({name, "_busy_end"}, PW'(busy), PW'(0));
        check({name, "_row_cnt"}, PW'(row_cnt), PW'(OW));
        tick();
        check({name, "_done_once"}, PW'(done), PW'(0));
    endtask

    localparam logic [PW-1:0] P1 = 21'b1111000_0110011_1010101;
    localparam logic [PW-1:0] P5 = 21'b1010011_0011001_1100110;
    localparam logic [PW-1:0] P6 = 21'b0111110_1001001_0101010;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        tick(); tick();
        check("rst_plane", plane, '0);
        check("rst_plane_valid", PW'(plane_valid), PW'(0));
        check("rst_busy", PW'(busy), PW'(0));
        check("rst_done", PW'(done), PW'(0));
        check("rst_row_cnt", PW'(row_cnt), PW'(0));
        rst = 1'b0;
        tick();

        // 1) back-to-back load
        full_load("t1", P1, 1'b0);
        check("t1_plane", plane, P1);

        // 3) abort after 10 bits
        pulse_start();
        send_bits(21'h1FFFFF, 0, 10, 1'b0);
        check("t3_row_cnt_mid", PW'(row_cnt), PW'(1));
        abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        check("t3_busy", PW'(busy), PW'(0));
        check("t3_row_cnt", PW'(row_cnt), PW'(0));
        check("t3_plane", plane, P1);
        check("t3_plane_valid", PW'(plane_valid), PW'(1));
        tick();

        // abort in IDLE has no effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_busy", PW'(busy), PW'(0));
        check("idle_abort_plane", plane, P1);

        // bit_valid in IDLE is ignored
        bit_valid = 1'b1; bit_in = 1'b1;
        tick(); tick();
        bit_valid = 1'b0; bit_in = 1'b0;
        check("idle_bits_row_cnt", PW'(row_cnt), PW'(0));

        // 2) same personality with random gaps
        full_load("t2", P1, 1'b1);
        check("t2_plane", plane, P1);

        // 4) bit presented together with start is dropped
        start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        exp_q.push_back('0);
        send_bits('0, 0, PW, 1'b0);
        check("t4_done_pulse", PW'(done), PW'(1));
        check("t4_plane", plane, '0);
        tick();

        // 5) start in LOAD is ignored
        pulse_start();
        exp_q.push_back(P5);
        send_bits(P5, 0, 5, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_busy_after_start", PW'(busy), PW'(1));
        send_bits(P5, 5, 16, 1'b0);
        check("t5_done_pulse", PW'(done), PW'(1));
        check("t5_plane", plane, P5);
        tick();

        // 6) reset mid-load clears everything
        pulse_start();
        send_bits(P1, 0, 14, 1'b0);
        check("t6_row_cnt_mid", PW'(row_cnt), PW'(2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_plane", plane, '0);
        check("t6_plane_valid", PW'(plane_valid), PW'(0));
        check("t6_busy", PW'(busy), PW'(0));
        check("t6_row_cnt", PW'(row_cnt), PW'(0));
        tick();
        pulse_start();
        exp_q.push_back(P6);
        send_bits(P6, 0, PW, 1'b0);
        check("t6_reload_done", PW'(done), PW'(1));
        // start during the done cycle is accepted
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_cycle_start_busy", PW'(busy), PW'(1));
        check("t6_reload_plane", plane, P6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("final_busy", PW'(busy), PW'(0));
        tick(); tick();

        check("sb_drained", PW'(exp_q.size()), PW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
